// File: rtl/character2_motion.sv
// Player-2 motion controller: samples controls once per frame and integrates
// walking, a jump/gravity arc and a timed kick into a registered sprite origin.
module character2_motion #(
    parameter int unsigned CharWidth   = 40,
    parameter int unsigned CharHeight  = 50,
    parameter int unsigned X_START     = 500,
    parameter int unsigned GROUND_Y    = 380,
    parameter int unsigned X_MIN       = 20,
    parameter int unsigned X_MAX       = 580,
    parameter int unsigned SPEED       = 3,
    parameter int unsigned JUMP_V      = 12,
    parameter int unsigned GRAVITY     = 1,
    parameter int unsigned KICK_FRAMES = 8
) (
    input  logic       vga_clk,
    input  logic       reset_n,
    input  logic       frame_tick,
    input  logic       key_left,
    input  logic       key_right,
    input  logic       key_jump,
    input  logic       key_kick,
    input  logic       freeze,
    input  logic       respawn,
    output logic [9:0] CharX,
    output logic [9:0] CharY,
    output logic       airborne,
    output logic       kicking
);

    // Keep the sprite on a 640x480 screen even if the limits are mis-set.
    localparam int unsigned XHi   = (X_MAX + CharWidth > 640) ? 640 - CharWidth : X_MAX;
    localparam int unsigned YGnd  = (GROUND_Y + CharHeight > 480) ? 480 - CharHeight : GROUND_Y;
    localparam int unsigned KickW = $clog2(KICK_FRAMES + 1);

    localparam logic [10:0]        XMinW    = 11'(X_MIN);
    localparam logic [10:0]        XHiW     = 11'(XHi);
    localparam logic [10:0]        SpeedW   = 11'(SPEED);
    localparam logic [9:0]         XStart   = 10'(X_START);
    localparam logic [9:0]         YGround  = 10'(YGnd);
    localparam logic [9:0]         YJump    = 10'(YGnd - JUMP_V);
    localparam logic signed [10:0] YGroundS = 11'(YGnd);
    localparam logic signed [5:0]  VyJump   = 6'(JUMP_V - 1);
    localparam logic signed [5:0]  VyGrav   = 6'(GRAVITY);
    localparam logic [KickW-1:0]   KickLoad = KickW'(KICK_FRAMES);

    typedef enum logic {StGround, StAir} state_e;

    state_e                state, state_next;
    logic signed [5:0]     vy, vy_next;
    logic [KickW-1:0]      kick_timer, kick_next;
    logic                  jump_prev, kick_prev;
    logic                  jump_edge, kick_edge;
    logic [10:0]           x_ext, x_dec, x_inc, x_next;
    logic signed [10:0]    y_air;
    logic [9:0]            y_next;
    logic                  unused_x_msb;

    assign unused_x_msb = x_next[10];

    always_comb begin
        jump_edge = key_jump & ~jump_prev;
        kick_edge = key_kick & ~kick_prev;

        // 11-bit arithmetic so stepping left near zero cannot wrap.
        x_ext  = {1'b0, CharX};
        x_dec  = (x_ext < XMinW + SpeedW) ? XMinW : x_ext - SpeedW;
        x_inc  = (x_ext + SpeedW > XHiW) ? XHiW : x_ext + SpeedW;
        x_next = x_ext;
        if (key_left && !key_right) begin
            x_next = x_dec;
        end else if (key_right && !key_left) begin
            x_next = x_inc;
        end

        y_air      = $signed({1'b0, CharY}) - $signed({{5{vy[5]}}, vy});
        y_next     = CharY;
        vy_next    = vy;
        state_next = state;
        unique case (state)
            StGround: begin
                if (jump_edge) begin
                    vy_next    = VyJump;
                    y_next     = YJump;
                    state_next = StAir;
                end else begin
                    y_next = YGround;
                end
            end
            StAir: begin
                vy_next = vy - VyGrav;
                if (y_air >= YGroundS) begin
                    y_next     = YGround;
                    vy_next    = '0;
                    state_next = StGround;
                end else if (y_air[10]) begin
                    y_next  = '0;
                    vy_next = '0;
                end else begin
                    y_next = y_air[9:0];
                end
            end
        endcase

        kick_next = kick_timer;
        if (kick_timer == '0) begin
            if (kick_edge) begin
                kick_next = KickLoad;
            end
        end else begin
            kick_next = kick_timer - KickW'(1);
        end
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            CharX      <= XStart;
            CharY      <= YGround;
            vy         <= '0;
            state      <= StGround;
            kick_timer <= '0;
            airborne   <= 1'b0;
            kicking    <= 1'b0;
            jump_prev  <= 1'b0;
            kick_prev  <= 1'b0;
        end else if (respawn) begin
            CharX      <= XStart;
            CharY      <= YGround;
            vy         <= '0;
            state      <= StGround;
            kick_timer <= '0;
            airborne   <= 1'b0;
            kicking    <= 1'b0;
            jump_prev  <= 1'b0;
            kick_prev  <= 1'b0;
        end else if (frame_tick && !freeze) begin
            CharX      <= x_next[9:0];
            CharY      <= y_next;
            vy         <= vy_next;
            state      <= state_next;
            airborne   <= (state_next == StAir);
            kick_timer <= kick_next;
            kicking    <= (kick_next != '0);
            jump_prev  <= key_jump;
            kick_prev  <= key_kick;
        end
    end

endmodule
